// File: rtl/dmem_pkg.sv
// Shared types and constants for the stalling data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [3:0] lane_mask_t;

  // Byte lanes written by a store; size is funct3[1:0].
  function automatic lane_mask_t store_mask(input logic [1:0] size, input logic [1:0] addr);
    lane_mask_t m;
    case (size)
      2'b00:   m = lane_mask_t'(4'b0001 << addr);
      2'b01:   m = addr[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: merges store data into a word and extracts/extends load data.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] store_word_o,
  output logic [31:0] load_data_o
);

  lane_mask_t  mask;
  logic [31:0] repl;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    mask = store_mask(funct3_i[1:0], addr_i);
    case (funct3_i[1:0])
      2'b00:   repl = {4{wdata_i[7:0]}};
      2'b01:   repl = {2{wdata_i[15:0]}};
      default: repl = wdata_i;
    endcase
    store_word_o = word_i;
    for (int unsigned i = 0; i < 4; i++) begin
      if (mask[i]) store_word_o[8*i +: 8] = repl[8*i +: 8];
    end
  end

  always_comb begin
    case (addr_i)
      2'd0:    ld_byte = word_i[7:0];
      2'd1:    ld_byte = word_i[15:8];
      2'd2:    ld_byte = word_i[23:16];
      default: ld_byte = word_i[31:24];
    endcase
    ld_half = addr_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    load_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    load_data_o = {{16{ld_half[15]}}, ld_half};
      F3_BU:   load_data_o = {24'h0, ld_byte};
      F3_HU:   load_data_o = {16'h0, ld_half};
      default: load_data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with configurable wait states,
// lane-merged stores and extended loads.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    f3_q, f3_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rerr_q, rerr_d;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   cur_word, st_word, ld_word;
  logic          accept, commit, req_err;

  assign accept   = req_valid & req_ready;
  assign commit   = (state_q == WAIT) && (cnt_q == 5'd1);
  assign cur_word = mem[addr_q[AW+1:2]];

  dmem_lane_align u_align (
    .word_i       (cur_word),
    .wdata_i      (wdata_q),
    .addr_i       (addr_q[1:0]),
    .funct3_i     (f3_q),
    .store_word_o (st_word),
    .load_data_o  (ld_word)
  );

  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      F3_B, F3_BU: req_err = 1'b0;
      F3_H, F3_HU: req_err = req_addr[0];
      F3_W:        req_err = (req_addr[1:0] != 2'b00);
      default:     req_err = 1'b1;
    endcase
    if (req_write && req_funct3[2]) req_err = 1'b1;
    if (req_addr[31:2] >= 30'(DEPTH_WORDS)) req_err = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  // Every access passes through WAIT; the counter is preloaded with
  // WAIT_CYCLES+1 so storage is touched from the captured request on its last edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d    = req_write;
          addr_d  = req_addr[AW+1:0];
          wdata_d = req_wdata;
          f3_d    = req_funct3;
          err_d   = req_err;
          cnt_d   = 5'(WAIT_CYCLES) + 5'd1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 5'd1;
        if (commit) begin
          rdata_d = (wr_q || err_q) ? '0 : ld_word;
          rerr_d  = err_q;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = rst && (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = rdata_q;
    rsp_err   = rerr_q;
  end

  always_ff @(posedge clk) begin
    if (commit && wr_q && !err_q) mem[addr_q[AW+1:2]] <= st_word;
  end

endmodule
